// File: rtl/flow_led_pkg.sv
// Shared types and constants for the LED flow controller.
// Stall detection is built only when LED_FLOW_STALL_DETECT_EN is defined.
package flow_led_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } flow_state_t;

   localparam int unsigned DEF_NUM_LEDS     = 8;
   localparam int unsigned DEF_STALL_CYCLES = 50_000_000;
   localparam int unsigned ARM_EDGES        = 3;
   localparam logic [31:0] RST_PAT          = 32'h0000_0001;

endpackage

// File: rtl/led_flow_ctrl_sync_edge_det.sv
// Two-flop synchronizer plus delay register giving a one-cycle strobe on
// either edge of an asynchronous input, held off for a few cycles after reset.
module sync_edge_det
   import flow_led_pkg::*;
(
   input  logic clk_in,
   input  logic rst,
   input  logic async_in,
   output logic edge_out
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_dly;
   logic [1:0] r_arm;
   logic       w_armed;

   assign w_armed = (r_arm == 2'(ARM_EDGES));

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_dly   <= 1'b0;
         r_arm   <= 2'd0;
      end else begin
         r_sync1 <= async_in;
         r_sync2 <= r_sync1;
         r_dly   <= r_sync2;
         // Saturating arm count masks the pipeline filling from reset zeros
         if (!w_armed) r_arm <= r_arm + 2'd1;
      end
   end

   assign edge_out = w_armed & (r_sync2 ^ r_dly);

endmodule

// File: rtl/led_flow_ctrl.sv
// One-hot LED chaser stepped by every edge of an asynchronous tick input.
// Optional tick-loss detector enabled by macro LED_FLOW_STALL_DETECT_EN.
module led_flow_ctrl
   import flow_led_pkg::*;
#(
   parameter int unsigned NUM_LEDS     = DEF_NUM_LEDS,
   parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES
)(
   input  logic                clk_in,
   input  logic                rst,
   input  logic                tick_in,
   input  logic                en,
   input  logic                dir,
   output logic [NUM_LEDS-1:0] led,
   output logic                step_pulse,
   output logic                stall
);

   logic                w_edge;
   logic                w_step;
   logic [NUM_LEDS-1:0] r_pat;
   logic [NUM_LEDS-1:0] w_pat_rot;
   logic [NUM_LEDS-1:0] w_pat_d;
   flow_state_t         r_state;

   sync_edge_det u_sync_edge_det (
      .clk_in   (clk_in),
      .rst      (rst),
      .async_in (tick_in),
      .edge_out (w_edge)
   );

   assign w_step    = w_edge & en;
   assign w_pat_rot = dir ? {r_pat[0], r_pat[NUM_LEDS-1:1]}
                          : {r_pat[NUM_LEDS-2:0], r_pat[NUM_LEDS-1]};
   assign w_pat_d   = w_step ? w_pat_rot : r_pat;

`ifdef LED_FLOW_STALL_DETECT_EN
   localparam int unsigned CNT_W = $clog2(STALL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   // Quiet-cycle counter; saturates at CNT_MAX while stalled
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!en || w_step) begin
         r_cnt <= '0;
      end else if (r_state != STALL && r_cnt != CNT_MAX) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_pat      <= NUM_LEDS'(RST_PAT);
         led        <= NUM_LEDS'(RST_PAT);
         step_pulse <= 1'b0;
`ifdef LED_FLOW_STALL_DETECT_EN
         stall      <= 1'b0;
`endif
      end else begin
         step_pulse <= w_step;
         r_pat      <= w_pat_d;
         led        <= w_pat_d;
`ifdef LED_FLOW_STALL_DETECT_EN
         stall      <= 1'b0;
`endif
         case (r_state)
            IDLE: if (en) r_state <= RUN;
            RUN: begin
               if (!en) begin
                  r_state <= IDLE;
`ifdef LED_FLOW_STALL_DETECT_EN
               end else if (!w_step && r_cnt == CNT_MAX) begin
                  r_state <= STALL;
                  led     <= '1;
                  stall   <= 1'b1;
`endif
               end
            end
`ifdef LED_FLOW_STALL_DETECT_EN
            // Pattern keeps its value underneath the all-ones display
            STALL: begin
               if (!en) begin
                  r_state <= IDLE;
               end else if (w_step) begin
                  r_state <= RUN;
               end else begin
                  led   <= '1;
                  stall <= 1'b1;
               end
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Self-checking bench for led_flow_ctrl: directed scenarios plus random
// stimulus against an event-level reference model.
module tb_led_flow_ctrl;

   localparam int unsigned N = 8;
   localparam int unsigned S = 16;
`ifdef LED_FLOW_STALL_DETECT_EN
   localparam bit STALL_ON = 1'b1;
`else
   localparam bit STALL_ON = 1'b0;
`endif

   logic         clk_in = 1'b0;
   logic         rst;
   logic         tick_in;
   logic         en;
   logic         dir;
   logic [N-1:0] led;
   logic         step_pulse;
   logic         stall;

   led_flow_ctrl #(.NUM_LEDS(N), .STALL_CYCLES(S)) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .tick_in    (tick_in),
      .en         (en),
      .dir        (dir),
      .led        (led),
      .step_pulse (step_pulse),
      .stall      (stall)
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_err = 0;
   int n_pulse = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: each observed tick level change becomes a step two
   // edges later; steps landing on the first three edges after reset vanish.
   int m_k;
   int m_pos;
   int m_q;
   bit m_stalled;
   bit m_pulse;
   bit m_ev;
   bit m_last_tick;
   int m_pend[$];

   always @(posedge clk_in) begin
      if (rst) begin
         m_k = 0; m_pos = 0; m_q = 0;
         m_stalled = 1'b0; m_pulse = 1'b0; m_last_tick = 1'b0;
         m_pend.delete();
      end else begin
         m_k++;
         m_ev = 1'b0;
         if (m_pend.size() > 0 && m_pend[0] == m_k) begin
            void'(m_pend.pop_front());
            m_ev = (m_k >= 4);
         end
         if (tick_in != m_last_tick) begin
            m_pend.push_back(m_k + 2);
            m_last_tick = tick_in;
         end
         m_pulse = m_ev && en;
         if (!en) begin
            m_q = 0; m_stalled = 1'b0;
         end else if (m_pulse) begin
            m_q = 0; m_stalled = 1'b0;
            m_pos = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
         end else if (!m_stalled) begin
            m_q++;
            if (STALL_ON && m_q >= S) m_stalled = 1'b1;
         end
      end
   end

   function automatic logic [N-1:0] model_led();
      logic [N-1:0] v;
      v = '0;
      v[m_pos] = 1'b1;
      if (m_stalled) v = '1;
      return v;
   endfunction

   // Drive inputs now (at a falling edge), pass one rising edge, compare.
   task automatic step(input bit tog, input bit e, input bit d, input bit r);
      if (tog) tick_in = ~tick_in;
      en = e; dir = d; rst = r;
      @(negedge clk_in);
      if (step_pulse === 1'b1) n_pulse++;
      if (!rst) begin
         chk("model_led", 32'(led), 32'(model_led()));
         chk("model_pulse", 32'(step_pulse), 32'(m_pulse));
         chk("model_stall", 32'(stall), 32'(m_stalled));
      end
   endtask

   task automatic idle(input int n, input bit e, input bit d);
      for (int i = 0; i < n; i++) step(1'b0, e, d, 1'b0);
   endtask

   bit r_tog, r_en, r_dir, r_rst;
   int dens;

   initial begin
      rst = 1'b1; tick_in = 1'b0; en = 1'b0; dir = 1'b0;
      @(negedge clk_in);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_led", 32'(led), 32'h01);
      chk("rst_pulse", 32'(step_pulse), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);

      // Three toggles ten cycles apart, each landing on the third edge
      idle(6, 1'b1, 1'b0);
      n_pulse = 0;
      for (int t = 0; t < 3; t++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0);
         chk("lat_old", 32'(led), 32'(8'h01 << t));
         step(1'b0, 1'b1, 1'b0, 1'b0);
         chk("lat_new", 32'(led), 32'(8'h02 << t));
         idle(7, 1'b1, 1'b0);
      end
      chk("seq_pulses", 32'(n_pulse), 32'd3);
      chk("seq_led", 32'(led), 32'h08);

      // Wrap in both directions
      for (int t = 0; t < 4; t++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         idle(4, 1'b1, 1'b0);
      end
      chk("pre_wrap", 32'(led), 32'h80);
      step(1'b1, 1'b1, 1'b0, 1'b0); idle(4, 1'b1, 1'b0);
      chk("wrap_up", 32'(led), 32'h01);
      step(1'b1, 1'b1, 1'b1, 1'b0); idle(4, 1'b1, 1'b1);
      chk("wrap_down", 32'(led), 32'h80);

      // Disabled steps are dropped
      n_pulse = 0;
      for (int t = 0; t < 4; t++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         idle(4, 1'b0, 1'b1);
      end
      chk("dis_pulses", 32'(n_pulse), 32'd0);
      chk("dis_led", 32'(led), 32'h80);
      step(1'b1, 1'b1, 1'b1, 1'b0); idle(4, 1'b1, 1'b1);
      chk("reen_led", 32'(led), 32'h40);

`ifdef LED_FLOW_STALL_DETECT_EN
      idle(20, 1'b1, 1'b1);
      chk("stall_flag", 32'(stall), 32'h1);
      chk("stall_led", 32'(led), 32'hFF);
      step(1'b1, 1'b1, 1'b1, 1'b0); idle(2, 1'b1, 1'b1);
      chk("unstall_flag", 32'(stall), 32'h0);
      chk("unstall_led", 32'(led), 32'h20);
`else
      idle(100, 1'b1, 1'b1);
      chk("nostall_flag", 32'(stall), 32'h0);
      chk("nostall_led", 32'(led), 32'h40);
`endif

      // Tick held high through reset release gives no step
      step(1'b0, 1'b1, 1'b0, 1'b1);
      tick_in = 1'b1;
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n_pulse = 0;
      idle(8, 1'b1, 1'b0);
      chk("rst_hi_pulses", 32'(n_pulse), 32'd0);
      chk("rst_hi_led", 32'(led), 32'h01);

      // Reset one cycle after a toggle abandons the step
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n_pulse = 0;
      idle(8, 1'b1, 1'b0);
      chk("abort_pulses", 32'(n_pulse), 32'd0);
      chk("abort_led", 32'(led), 32'h01);

      // Random stimulus in phases of varying tick density
      r_dir = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) begin
            case ((i / 500) % 3)
               0:       dens = 3;
               1:       dens = 15;
               default: dens = 50;
            endcase
         end
         r_tog = ($urandom_range(0, 99) < dens);
         r_en  = ($urandom_range(0, 99) < 92);
         if ($urandom_range(0, 9) == 0) r_dir = ~r_dir;
         r_rst = ($urandom_range(0, 399) == 0);
         step(r_tog, r_en, r_dir, r_rst);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/led_flow_ctrl.md
LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, meaning LED count and width of led; legal range 2..32.
REQ-002 SHALL have parameter STALL_CYCLES, default 50_000_000, meaning clk_in cycles without a tick edge before stall is declared; must be at least 2.
REQ-003 SHALL have port clk_in, input, width 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-005 SHALL have port tick_in, input, width 1: asynchronous toggling step clock; every transition, rising or falling, is one step.
REQ-006 SHALL have port en, input, width 1: synchronous run enable.
REQ-007 SHALL have port dir, input, width 1: 0 rotates toward MSB, 1 rotates toward LSB.
REQ-008 SHALL have port led, output, width NUM_LEDS: registered LED drive.
REQ-009 SHALL have port step_pulse, output, width 1: registered one-cycle strobe per accepted step.
REQ-010 SHALL have port stall, output, width 1: registered tick-loss flag.

Function
REQ-011 SHALL synchronize tick_in through 2 flip-flops, then detect both edges against a third delay register.
REQ-012 SHALL handle a tick_in transition that meets setup before clk_in edge N as follows: update led and assert step_pulse at edge N+2 (3rd edge).
REQ-013 SHALL suppress edge detection for the first 3 clk_in edges after reset release, so no spurious step occurs when tick_in=1 at reset.
REQ-014 SHALL hold internal pattern pat as one-hot NUM_LEDS bits; an accepted step with dir=0 does pat <= {pat[N-2:0],pat[N-1]}, and with dir=1 does {pat[0],pat[N-1:1]}.
REQ-015 SHALL wrap around: MSB to bit0 when dir=0, bit0 to MSB when dir=1.
REQ-016 SHALL sample en and dir at the edge where the step would apply; with en=0 the edge is dropped, step_pulse=0 and pat holds.
REQ-017 SHALL apply a dir change only to the next step, never re-applying the previous one.
REQ-018 SHALL implement FSM states IDLE, RUN and STALL (STALL only per REQ-028).
REQ-019 SHALL make these FSM transitions:
  - IDLE->RUN when en=1.
  - RUN->IDLE when en=0.
  - RUN->STALL when the stall counter reaches STALL_CYCLES-1.
  - STALL->RUN on an accepted edge.
  - STALL->IDLE when en=0.
REQ-020 SHALL drive led=pat in IDLE and RUN, and all-ones in STALL; pat is preserved while in STALL.
REQ-021 SHALL handle an edge arriving in STALL in the same cycle: stall clears, pat advances one step, step_pulse=1 and led=new pat.
REQ-022 SHALL size the stall counter at $clog2(STALL_CYCLES) bits and never let it wrap; it saturates in STALL.
REQ-023 SHALL clear the stall counter on every accepted edge and while en=0.

Reset
REQ-024 SHALL asynchronously set, on rst=1: pat=1 (bit0), led=1, step_pulse=0, stall=0, FSM=IDLE, counter=0, synchronizer and delay registers=0, and the arm count=0.
REQ-025 SHALL abandon a step in flight when rst asserts mid-step; no step is produced after release.

Configuration
REQ-026 SHALL gate the stall detector with macro LED_FLOW_STALL_DETECT_EN.
REQ-027 SHALL, with the macro defined, implement the counter, STALL state and stall output as above.
REQ-028 SHALL, without the macro, omit the counter and STALL state, tie stall to 0 and make led=pat always; all other behaviour is unchanged.

Structure
REQ-029 SHALL place the FSM state enum (IDLE/RUN/STALL), default NUM_LEDS/STALL_CYCLES constants and the reset pattern constant in package flow_led_pkg.
REQ-030 SHALL place the 2-FF synchronizer, delay register, arm counter and edge strobe in sub-module sync_edge_det (ports clk_in, rst, async_in, edge_out).

Verification
REQ-031 SHALL cover, with NUM_LEDS=8, en=1, dir=0 and 3 tick_in toggles spaced 10 cycles apart: led goes 0x02, 0x04, 0x08, each 3 edges after its toggle, with exactly 3 step_pulse cycles.
REQ-032 SHALL cover wrap: from led=0x80 with dir=0 one toggle gives led=0x01; then dir=1 and one toggle gives led=0x80.
REQ-033 SHALL cover disable: en=0 with 4 toggles gives led unchanged and step_pulse never high; en=1 with one toggle advances exactly 1 position.
REQ-034 SHALL cover stall with the macro on and STALL_CYCLES=16: no toggle for 16 cycles gives stall=1 and led=0xFF; the next toggle clears stall with led=previous pattern advanced by 1.
REQ-035 SHALL cover reset with tick_in held 1 through rst release: no step_pulse and led=0x01; rst asserted 1 cycle after a toggle gives led=0x01 and no pulse after release.
REQ-036 SHALL cover the macro-off build: 100 idle cycles give stall=0 and led unchanged.
